// File: rtl/ap_cell_bank_if.sv
// Write, read and stream-unload channels of the associative-processor cell bank.
// The master side drives requests; the slave side (the bank) returns data and
// handshakes.
interface ap_cell_bank_if #(
  parameter int DATA_WIDTH     = 4,
  parameter int DATA_DEPTH     = 4,
  parameter int ADDR_WIDTH_CAM = 8
) ();

  logic [2:0]                in_mode;
  logic                      wr_valid;
  logic                      wr_ready;
  logic [ADDR_WIDTH_CAM-1:0] wr_row_addr;
  logic [ADDR_WIDTH_CAM-1:0] wr_col_addr;
  logic [DATA_WIDTH-1:0]     ip_row;
  logic [DATA_DEPTH-1:0]     ip_col;

  logic                      rd_en;
  logic                      rd_mode;
  logic [ADDR_WIDTH_CAM-1:0] rd_addr;
  logic [DATA_WIDTH-1:0]     q_out_row;
  logic [DATA_DEPTH-1:0]     q_out_col;
  logic                      rd_valid;

  logic                      st_start;
  logic                      st_valid;
  logic                      st_ready;
  logic [DATA_DEPTH-1:0]     st_data;
  logic [ADDR_WIDTH_CAM-1:0] st_col;
  logic                      st_last;
  logic                      st_busy;

  modport master (
    output in_mode, wr_valid, wr_row_addr, wr_col_addr, ip_row, ip_col,
    output rd_en, rd_mode, rd_addr, st_start, st_ready,
    input  wr_ready, q_out_row, q_out_col, rd_valid,
    input  st_valid, st_data, st_col, st_last, st_busy
  );

  modport slave (
    input  in_mode, wr_valid, wr_row_addr, wr_col_addr, ip_row, ip_col,
    input  rd_en, rd_mode, rd_addr, st_start, st_ready,
    output wr_ready, q_out_row, q_out_col, rd_valid,
    output st_valid, st_data, st_col, st_last, st_busy
  );

endinterface

// File: rtl/ap_cell_bank.sv
// DATA_DEPTH x DATA_WIDTH associative-processor cell array with handshaked
// row/column writes, operand-plane copies, tagged/masked write-back, a
// registered row/column read port and a column-stream unload FSM.
// Optional: define AP_CELL_RDFWD_EN to forward a same-cycle fired write
// (not write-back) to the read port.
module ap_cell_bank #(
  parameter int DATA_WIDTH     = 4,
  parameter int DATA_DEPTH     = 4,
  parameter int ADDR_WIDTH_CAM = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  ap_cell_bank_if.slave                    bus,
  input  logic [DATA_WIDTH*DATA_DEPTH-1:0] q_a,
  input  logic [DATA_WIDTH*DATA_DEPTH-1:0] q_b,
  input  logic [DATA_DEPTH-1:0]            q_s,
  input  logic                             abs_opt,
  input  logic [2:0]                       pass,
  input  logic [DATA_DEPTH-1:0]            tag,
  input  logic [DATA_WIDTH-1:0]            mask,
  output logic [DATA_WIDTH*DATA_DEPTH-1:0] q
);

  localparam int NCELL = DATA_WIDTH * DATA_DEPTH;

  typedef enum logic [2:0] {
    MODE_ROW    = 3'd1,
    MODE_COL    = 3'd2,
    MODE_COPY_B = 3'd3,
    MODE_COPY_A = 3'd5
  } wr_mode_e;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_STREAM} state_e;

  state_e                    state, state_nxt;
  logic                      wr_fire;
  logic [NCELL-1:0]          wr_view, wr_hit, q_nxt, rd_src;
  logic [DATA_DEPTH-1:0]     wb_inv;
  logic [DATA_WIDTH-1:0]     rd_row_sel;
  logic [DATA_DEPTH-1:0]     rd_col_sel;
  logic [DATA_WIDTH-1:0]     q_out_row_q;
  logic [DATA_DEPTH-1:0]     q_out_col_q;
  logic                      rd_valid_q;
  logic [ADDR_WIDTH_CAM-1:0] col_sel;
  logic [DATA_DEPTH-1:0]     col_data;
  logic                      st_valid_q, st_valid_nxt;
  logic                      st_last_q, st_last_nxt;
  logic [ADDR_WIDTH_CAM-1:0] st_col_q, st_col_nxt;
  logic [DATA_DEPTH-1:0]     st_data_q, st_data_nxt;

  assign wr_fire       = bus.wr_valid && (state == S_IDLE);
  assign bus.wr_ready  = (state == S_IDLE);
  assign bus.st_busy   = (state != S_IDLE);
  assign bus.rd_valid  = rd_valid_q;
  assign bus.q_out_row = q_out_row_q;
  assign bus.q_out_col = q_out_col_q;
  assign bus.st_valid  = st_valid_q;
  assign bus.st_last   = st_last_q;
  assign bus.st_col    = st_col_q;
  assign bus.st_data   = st_data_q;

  // Array as seen after the fired write only (no write-back); wr_hit marks written cells.
  always_comb begin
    wr_view = q;
    wr_hit  = '0;
    if (wr_fire) begin
      for (int unsigned i = 0; i < DATA_DEPTH; i++) begin
        for (int unsigned j = 0; j < DATA_WIDTH; j++) begin
          if (bus.in_mode == MODE_COPY_A) begin
            wr_hit[i*DATA_WIDTH+j]  = 1'b1;
            wr_view[i*DATA_WIDTH+j] = q_a[i*DATA_WIDTH+j];
          end else if (bus.in_mode == MODE_COPY_B) begin
            wr_hit[i*DATA_WIDTH+j]  = 1'b1;
            wr_view[i*DATA_WIDTH+j] = q_b[i*DATA_WIDTH+j];
          end else if (bus.in_mode == MODE_ROW && bus.wr_row_addr == ADDR_WIDTH_CAM'(i)) begin
            wr_hit[i*DATA_WIDTH+j]  = 1'b1;
            wr_view[i*DATA_WIDTH+j] = bus.ip_row[j];
          end else if (bus.in_mode == MODE_COL && bus.wr_col_addr == ADDR_WIDTH_CAM'(j)) begin
            wr_hit[i*DATA_WIDTH+j]  = 1'b1;
            wr_view[i*DATA_WIDTH+j] = bus.ip_col[i];
          end
        end
      end
    end
  end

  // Next array: frozen while unloading, else fired write, else tagged/masked write-back.
  always_comb begin
    q_nxt = q;
    for (int unsigned i = 0; i < DATA_DEPTH; i++) begin
      wb_inv[i] = abs_opt ? (q_s[i] && (pass == 3'd2 || pass == 3'd3))
                          : (pass == 3'd1 || pass == 3'd2);
    end
    if (state == S_IDLE) begin
      for (int unsigned i = 0; i < DATA_DEPTH; i++) begin
        for (int unsigned j = 0; j < DATA_WIDTH; j++) begin
          if (wr_hit[i*DATA_WIDTH+j])
            q_nxt[i*DATA_WIDTH+j] = wr_view[i*DATA_WIDTH+j];
          else if (tag[i] && mask[j])
            q_nxt[i*DATA_WIDTH+j] = q_a[i*DATA_WIDTH+j] ^ wb_inv[i];
        end
      end
    end
  end

`ifdef AP_CELL_RDFWD_EN
  assign rd_src = wr_view;
`else
  assign rd_src = q;
`endif

  // Read-port selection; out-of-range addresses match nothing and yield zero.
  always_comb begin
    rd_row_sel = '0;
    rd_col_sel = '0;
    for (int unsigned i = 0; i < DATA_DEPTH; i++) begin
      if (bus.rd_addr == ADDR_WIDTH_CAM'(i))
        rd_row_sel = rd_src[i*DATA_WIDTH +: DATA_WIDTH];
      for (int unsigned j = 0; j < DATA_WIDTH; j++) begin
        if (bus.rd_addr == ADDR_WIDTH_CAM'(j))
          rd_col_sel[i] = rd_src[i*DATA_WIDTH+j];
      end
    end
  end

  // Column to present on the next beat: column 0 from LOAD, else the following column.
  always_comb begin
    col_sel  = (state == S_LOAD) ? '0 : st_col_q + ADDR_WIDTH_CAM'(1);
    col_data = '0;
    for (int unsigned i = 0; i < DATA_DEPTH; i++) begin
      for (int unsigned j = 0; j < DATA_WIDTH; j++) begin
        if (col_sel == ADDR_WIDTH_CAM'(j))
          col_data[i] = q[i*DATA_WIDTH+j];
      end
    end
  end

  // Unload FSM next-state and stream outputs.
  always_comb begin
    state_nxt    = state;
    st_valid_nxt = st_valid_q;
    st_last_nxt  = st_last_q;
    st_col_nxt   = st_col_q;
    st_data_nxt  = st_data_q;
    case (state)
      S_IDLE: begin
        if (bus.st_start) state_nxt = S_LOAD;
      end
      S_LOAD: begin
        st_col_nxt   = '0;
        st_data_nxt  = col_data;
        st_valid_nxt = 1'b1;
        st_last_nxt  = (DATA_WIDTH == 1);
        state_nxt    = S_STREAM;
      end
      S_STREAM: begin
        if (st_valid_q && bus.st_ready) begin
          if (st_last_q) begin
            st_valid_nxt = 1'b0;
            st_last_nxt  = 1'b0;
            state_nxt    = S_IDLE;
          end else begin
            st_col_nxt  = col_sel;
            st_data_nxt = col_data;
            st_last_nxt = (col_sel == ADDR_WIDTH_CAM'(DATA_WIDTH - 1));
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // Array, read-port and stream output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q           <= '0;
      q_out_row_q <= '0;
      q_out_col_q <= '0;
      rd_valid_q  <= 1'b0;
      st_valid_q  <= 1'b0;
      st_last_q   <= 1'b0;
      st_col_q    <= '0;
      st_data_q   <= '0;
    end else begin
      q          <= q_nxt;
      rd_valid_q <= bus.rd_en;
      if (bus.rd_en) begin
        if (bus.rd_mode) q_out_col_q <= rd_col_sel;
        else             q_out_row_q <= rd_row_sel;
      end
      st_valid_q <= st_valid_nxt;
      st_last_q  <= st_last_nxt;
      st_col_q   <= st_col_nxt;
      st_data_q  <= st_data_nxt;
    end
  end

endmodule

// File: tb/tb_ap_cell_bank.sv
// Self-checking bench for ap_cell_bank: directed plan steps followed by a
// randomized run, all compared against a cell-rule / beat-queue reference model.
module tb_ap_cell_bank;

  localparam int W = 4;
  localparam int D = 4;
  localparam int A = 8;
  localparam int N = W * D;

  typedef struct {
    int           col;
    logic [D-1:0] data;
  } beat_t;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [N-1:0] q_a, q_b, q;
  logic [D-1:0] q_s, tag;
  logic         abs_opt;
  logic [2:0]   pass;
  logic [W-1:0] mask;

  ap_cell_bank_if #(.DATA_WIDTH(W), .DATA_DEPTH(D), .ADDR_WIDTH_CAM(A)) bus ();

  ap_cell_bank #(.DATA_WIDTH(W), .DATA_DEPTH(D), .ADDR_WIDTH_CAM(A)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .q_a(q_a), .q_b(q_b), .q_s(q_s), .abs_opt(abs_opt), .pass(pass),
    .tag(tag), .mask(mask), .q(q)
  );

  always #5 clk = ~clk;

  int unsigned  n_checks = 0;
  int unsigned  n_fail   = 0;

  // Reference model state
  logic [N-1:0] exp_q;
  bit           loading;
  beat_t        beats[$];
  int           exp_col;
  logic [D-1:0] exp_data;
  bit           exp_rv;
  logic [W-1:0] exp_row;
  logic [D-1:0] exp_colv;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.in_mode = 3'd0; bus.wr_valid = 1'b0; bus.wr_row_addr = '0; bus.wr_col_addr = '0;
    bus.ip_row = '0; bus.ip_col = '0; bus.rd_en = 1'b0; bus.rd_mode = 1'b0; bus.rd_addr = '0;
    bus.st_start = 1'b0; bus.st_ready = 1'b0;
    q_a = '0; q_b = '0; q_s = '0; abs_opt = 1'b0; pass = 3'd0; tag = '0; mask = '0;
  endtask

  task automatic model_reset();
    exp_q = '0; loading = 0; beats.delete(); exp_col = 0; exp_data = '0;
    exp_rv = 0; exp_row = '0; exp_colv = '0;
  endtask

  // Cell-by-cell rule evaluation; write_only drops the write-back rules.
  function automatic logic [N-1:0] model_next(input logic [N-1:0] cur, input bit busy, input bit write_only);
    logic [N-1:0] r;
    bit wrote, inv;
    r = cur;
    if (!busy) begin
      for (int i = 0; i < D; i++) begin
        for (int j = 0; j < W; j++) begin
          wrote = 0;
          if (bus.wr_valid) begin
            if (bus.in_mode == 3'd5) begin r[i*W+j] = q_a[i*W+j]; wrote = 1; end
            else if (bus.in_mode == 3'd3) begin r[i*W+j] = q_b[i*W+j]; wrote = 1; end
            else if (bus.in_mode == 3'd1 && int'(bus.wr_row_addr) == i) begin r[i*W+j] = bus.ip_row[j]; wrote = 1; end
            else if (bus.in_mode == 3'd2 && int'(bus.wr_col_addr) == j) begin r[i*W+j] = bus.ip_col[i]; wrote = 1; end
          end
          if (!wrote && !write_only && tag[i] && mask[j]) begin
            if (abs_opt) inv = q_s[i] && (pass == 2 || pass == 3);
            else         inv = (pass == 1 || pass == 2);
            r[i*W+j] = inv ? ~q_a[i*W+j] : q_a[i*W+j];
          end
        end
      end
    end
    return r;
  endfunction

  // Advance one clock with the currently driven inputs and check every output.
  task automatic cycle();
    logic [N-1:0] nq, src;
    bit busy_now, busy_after;
    beat_t b;
    busy_now = loading || (beats.size() != 0);
    nq = model_next(exp_q, busy_now, 1'b0);
    exp_rv = bus.rd_en;
    if (bus.rd_en) begin
`ifdef AP_CELL_RDFWD_EN
      src = model_next(exp_q, busy_now, 1'b1);
`else
      src = exp_q;
`endif
      if (!bus.rd_mode) begin
        exp_row = '0;
        if (int'(bus.rd_addr) < D) exp_row = src[int'(bus.rd_addr)*W +: W];
      end else begin
        exp_colv = '0;
        if (int'(bus.rd_addr) < W)
          for (int i = 0; i < D; i++) exp_colv[i] = src[i*W + int'(bus.rd_addr)];
      end
    end
    if (beats.size() != 0) begin
      if (bus.st_ready) void'(beats.pop_front());
    end else if (loading) begin
      for (int c = 0; c < W; c++) begin
        b.col = c;
        for (int i = 0; i < D; i++) b.data[i] = nq[i*W+c];
        beats.push_back(b);
      end
      loading = 0;
    end else if (bus.st_start) begin
      loading = 1;
    end
    exp_q = nq;
    @(posedge clk); #1;
    if (beats.size() != 0) begin exp_col = beats[0].col; exp_data = beats[0].data; end
    busy_after = loading || (beats.size() != 0);
    chk("q", q, exp_q);
    chk("wr_ready", bus.wr_ready, !busy_after);
    chk("st_busy", bus.st_busy, busy_after);
    chk("st_valid", bus.st_valid, beats.size() != 0);
    chk("st_last", bus.st_last, beats.size() == 1);
    chk("st_col", bus.st_col, exp_col);
    chk("st_data", bus.st_data, exp_data);
    chk("rd_valid", bus.rd_valid, exp_rv);
    chk("q_out_row", bus.q_out_row, exp_row);
    chk("q_out_col", bus.q_out_col, exp_colv);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired: observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] saved;
    idle_inputs();
    model_reset();

    // 1: reset state, then ROW write
    repeat (2) @(posedge clk);
    #1;
    chk("rst_q", q, 16'h0);
    chk("rst_wr_ready", bus.wr_ready, 1'b1);
    chk("rst_st_busy", bus.st_busy, 1'b0);
    chk("rst_rd_valid", bus.rd_valid, 1'b0);
    @(negedge clk); rst = 1'b1;
    bus.in_mode = 3'd1; bus.wr_valid = 1'b1; bus.wr_row_addr = 8'd2; bus.ip_row = 4'b1011;
    cycle();
    chk("s1_row2", q[11:8], 4'b1011);
    idle_inputs();

    // 2: clear via COPY_B, then COL write
    bus.in_mode = 3'd3; bus.wr_valid = 1'b1; q_b = '0;
    cycle();
    bus.in_mode = 3'd2; bus.wr_col_addr = 8'd1; bus.ip_col = 4'b0110;
    cycle();
    chk("s2_col1", q, 16'h0220);
    idle_inputs();

    // 4: column read, in range and out of range
    bus.rd_en = 1'b1; bus.rd_mode = 1'b1; bus.rd_addr = 8'd1;
    cycle();
    chk("s4_rd_valid", bus.rd_valid, 1'b1);
    chk("s4_col1", bus.q_out_col, 4'b0110);
    bus.rd_addr = 8'd9;
    cycle();
    chk("s4_col_oor", bus.q_out_col, 4'b0000);
    idle_inputs();

    // 3: write-back with inversion, then absolute mode
    q_a = 16'hFFFF; tag = 4'b0001; mask = 4'hF; abs_opt = 1'b0; pass = 3'd1;
    cycle();
    chk("s3_inv_row0", q[3:0], 4'h0);
    chk("s3_hold_rows", q[15:4], 12'h022);
    abs_opt = 1'b1; q_s = 4'b0001;
    cycle();
    chk("s3_abs_row0", q[3:0], 4'hF);
    idle_inputs();

    // 5: unload with backpressure and a blocked write
    bus.st_start = 1'b1;
    cycle();
    bus.st_start = 1'b0;
    cycle();
    saved = q;
    bus.in_mode = 3'd1; bus.wr_valid = 1'b1; bus.wr_row_addr = 8'd0; bus.ip_row = 4'hA;
    for (int k = 0; k < 3; k++) begin
      chk("s5_wr_ready_busy", bus.wr_ready, 1'b0);
      cycle();
      chk("s5_q_frozen", q, saved);
    end
    idle_inputs();
    bus.st_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("s5_beat_valid", bus.st_valid, 1'b1);
      chk("s5_beat_col", bus.st_col, k);
      chk("s5_beat_last", bus.st_last, k == 3);
      cycle();
    end
    chk("s5_done_valid", bus.st_valid, 1'b0);
    chk("s5_done_busy", bus.st_busy, 1'b0);

    // 6: asynchronous reset during beat 2
    bus.st_start = 1'b1;
    cycle();
    bus.st_start = 1'b0;
    repeat (3) cycle();
    chk("s6_beat2", bus.st_col, 2);
    rst = 1'b0;
    #1;
    chk("s6_rst_valid", bus.st_valid, 1'b0);
    chk("s6_rst_busy", bus.st_busy, 1'b0);
    model_reset();
    idle_inputs();
    @(negedge clk); rst = 1'b1;
    #1;
    chk("s6_wr_ready", bus.wr_ready, 1'b1);
    chk("s6_q_cleared", q, 16'h0);

    // Randomized run
    for (int it = 0; it < 600; it++) begin
      bus.in_mode     = 3'($urandom_range(0, 7));
      bus.wr_valid    = 1'($urandom_range(0, 1));
      bus.wr_row_addr = 8'($urandom_range(0, 5));
      bus.wr_col_addr = 8'($urandom_range(0, 5));
      bus.ip_row      = 4'($urandom);
      bus.ip_col      = 4'($urandom);
      bus.rd_en       = 1'($urandom_range(0, 1));
      bus.rd_mode     = 1'($urandom_range(0, 1));
      bus.rd_addr     = 8'($urandom_range(0, 5));
      bus.st_start    = ($urandom_range(0, 7) == 0);
      bus.st_ready    = 1'($urandom_range(0, 1));
      q_a             = 16'($urandom);
      q_b             = 16'($urandom);
      q_s             = 4'($urandom);
      abs_opt         = 1'($urandom_range(0, 1));
      pass            = 3'($urandom_range(0, 7));
      tag             = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
      mask            = 4'($urandom);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
